// File: rtl/iomem_arbiter_if.sv
`default_nettype none
// ============================================================================
// iomem_arbiter_if : picosoc-style iomem handshake bundle (valid/ready + bus)
// Rev 1.0
// ============================================================================
interface iomem_arbiter_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   // master issues requests; slave answers with ready/rdata
   modport master (
      output valid, wstrb, addr, wdata,
      input  ready, rdata
   );

   modport slave (
      input  valid, wstrb, addr, wdata,
      output ready, rdata
   );
endinterface
`default_nettype wire

// File: rtl/iomem_arbiter.sv
`default_nettype none
// ============================================================================
// iomem_arbiter : two-master round-robin arbiter onto one iomem slave,
//                 with per-transaction wait timeout and sticky error flag
// Rev 1.0
// ============================================================================
module iomem_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic                   clk,
   input  logic                   resetn,
   iomem_arbiter_if.slave         m0,
   iomem_arbiter_if.slave         m1,
   iomem_arbiter_if.master        s,
   output logic [1:0]             grant,
   output logic                   err_timeout,
   input  logic                   err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_wait_cnt;
   logic        r_last_grant;   // 0: m0 was granted last, 1: m1

   logic        w_any_req;
   logic        w_pick_m1;
   logic [31:0] w_req_addr;
   logic [31:0] w_req_wdata;
   logic [3:0]  w_req_wstrb;
   logic        w_timeout;
   logic        w_done;
   logic [31:0] w_resp_data;

   // m1 wins when it is the only requester, or both request and m0 went last
   always_comb begin
      w_any_req   = m0.valid | m1.valid;
      w_pick_m1   = m1.valid & (~m0.valid | ~r_last_grant);
      w_req_addr  = w_pick_m1 ? m1.addr  : m0.addr;
      w_req_wdata = w_pick_m1 ? m1.wdata : m0.wdata;
      w_req_wstrb = w_pick_m1 ? m1.wstrb : m0.wstrb;
      w_timeout   = (r_state == ST_BUSY) && !s.ready && (r_wait_cnt == c_wait_last);
      w_done      = (r_state == ST_BUSY) && (s.ready || (r_wait_cnt == c_wait_last));
      w_resp_data = s.ready ? s.rdata : ERR_DATA;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_wait_cnt   <= 8'd0;
         r_last_grant <= 1'b1;
         grant        <= 2'b00;
         err_timeout  <= 1'b0;
         s.valid      <= 1'b0;
         s.addr       <= 32'd0;
         s.wdata      <= 32'd0;
         s.wstrb      <= 4'd0;
         m0.ready     <= 1'b0;
         m0.rdata     <= 32'd0;
         m1.ready     <= 1'b0;
         m1.rdata     <= 32'd0;
      end else begin
         // a timeout raised this cycle outranks a concurrent clear
         if (w_timeout) begin
            err_timeout <= 1'b1;
         end else if (err_clr) begin
            err_timeout <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  s.addr       <= w_req_addr;
                  s.wdata      <= w_req_wdata;
                  s.wstrb      <= w_req_wstrb;
                  s.valid      <= 1'b1;
                  grant        <= w_pick_m1 ? 2'b10 : 2'b01;
                  r_last_grant <= w_pick_m1;
                  r_wait_cnt   <= 8'd0;
                  r_state      <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               if (w_done) begin
                  if (grant[1]) begin
                     m1.rdata <= w_resp_data;
                     m1.ready <= 1'b1;
                  end else begin
                     m0.rdata <= w_resp_data;
                     m0.ready <= 1'b1;
                  end
                  s.valid <= 1'b0;
                  r_state <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end

            ST_RESP: begin
               m0.ready <= 1'b0;
               m1.ready <= 1'b0;
               grant    <= 2'b00;
               r_state  <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   a_svalid_busy_only : assert property (@(posedge clk) disable iff (!resetn)
      s.valid |-> (r_state == ST_BUSY));
   a_ready_exclusive  : assert property (@(posedge clk) disable iff (!resetn)
      !(m0.ready && m1.ready));
   a_grant_onehot     : assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(grant));

endmodule
`default_nettype wire
